ppa_arbiter: RTL and testbench
==============================

Name: ppa_arbiter

Overview:
- Shares one 16-bit parallel-prefix adder (`ppa`, instantiated internally, combinational) among NREQ requesters.
- Arbitration is round-robin with a valid/ready handshake on each requester.
- The sum, carry-out and requester ID are registered into a single-entry response stage with its own valid/ready handshake.
- Sits between the client units and the shared adder datapath. It is the only block allowed to drive the adder operands.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, width of the requester ID; must equal $clog2(NREQ).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active low; sampled on the rising edge of clk.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  input  16*NREQ  operand A; requester i occupies bits [16*i+15:16*i].
- req_b  input  16*NREQ  operand B; same packing as req_a.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  index of the requester that owns the response.
- rsp_sum  output  16  A+B modulo 2^16.
- rsp_co  output  1  carry-out of A+B.

Behaviour:
- Reset (rst_n=0 at a clock edge) clears the following; it overrides any handshake in flight:
  - rsp_valid=0, rsp_sum=0, rsp_co=0, rsp_id=0.
  - Round-robin pointer ptr=0.
  - An in-flight response is discarded.
- req_ready is combinational and is 0 on all bits while rst_n=0.
- Grant selection (combinational):
  - grant = the first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - If no req_valid bit is set, there is no grant.
- Readiness:
  - can_load = ~rsp_valid | rsp_ready.
  - req_ready[i] = (i==grant) & can_load & rst_n.
  - req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- Accept (req_valid[g] & req_ready[g]) at edge N:
  - Adder operands are muxed from requester g.
  - rsp_sum, rsp_co and rsp_id=g are loaded, and rsp_valid=1 is visible after edge N.
  - Latency is 1 cycle.
  - ptr <= (g+1) mod NREQ.
- Response drain: rsp_valid & rsp_ready with no accept in the same cycle clears rsp_valid to 0. Data registers hold their values.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one, rsp_valid stays 1, and throughput is one result per clock.
- Backpressure: while rsp_valid=1 and rsp_ready=0:
  - all req_ready bits are 0;
  - rsp_* outputs are held stable;
  - ptr is unchanged.
- Idle: ptr does not move when no request is accepted.
- Operand mux when no grant: the mux drives 0 into the adder. The adder output is then don't-care and is not loaded.
- Requester protocol:
  - Once req_valid[i] is raised, the requester holds it and its operands stable until it sees req_ready[i].
  - The arbiter does not check this; the bench asserts it.
- Fairness: any requester holding valid is granted within NREQ accepts.
- Arithmetic: {rsp_co, rsp_sum} = req_a_i + req_b_i as a 17-bit unsigned sum. Carry-in is always 0.

Optional Feature:
- Macro: PPA_ARBITER_STRICT0_EN.
- Defined:
  - Requester 0 has strict priority. If req_valid[0]=1, grant=0 regardless of ptr.
  - A grant to requester 0 does not update ptr.
  - All other requesters remain round-robin.
- Not defined: pure round-robin for all requesters, as described above.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all req_valid=1 -> req_ready=0 on all bits, rsp_valid=0, rsp_sum=0, rsp_id=0. After rst_n=1, first grant goes to requester 0.
- Single add: req 2 alone drives A=16'hFFFF, B=16'h0001 with rsp_ready=1 -> accepted at edge N; at N+1 rsp_valid=1, rsp_id=2, rsp_sum=16'h0000, rsp_co=1.
- Round-robin: all 4 valid continuously with rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1. Back-to-back rsp_valid=1 every cycle.
- Backpressure: rsp_ready=0 for 5 cycles with a pending response of 16'h1234+16'h4321 -> rsp_sum=16'h5555 held, all req_ready=0, ptr frozen. Releasing rsp_ready gives a same-cycle drain and accept.
- Wrap and skip: ptr=3 with only req 1 valid, A=16'h8000, B=16'h8000 -> grant 1, rsp_sum=0, rsp_co=1, next ptr=2.
- Strict priority (PPA_ARBITER_STRICT0_EN): reqs 0 and 3 valid continuously -> rsp_id always 0. Macro undefined -> rsp_id alternates 0,3,0,3.

Source files
------------

// File: rtl/ppa_arbiter.sv
// Round-robin arbiter sharing one 16-bit Kogge-Stone adder among NREQ clients.
// Define PPA_ARBITER_STRICT0_EN to give requester 0 strict priority.
module ppa (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o,
    output logic        co_o
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] gn;
    logic [15:0] pn;

    always_comb begin
        g = a_i & b_i;
        p = a_i ^ b_i;
        gn = g;
        pn = p;
        for (int d = 1; d < 16; d = d << 1) begin
            gn = g;
            pn = p;
            for (int i = d; i < 16; i++) begin
                gn[i] = g[i] | (p[i] & g[i-d]);
                pn[i] = p[i] & p[i-d];
            end
            g = gn;
            p = pn;
        end
        // g[i] now holds the carry out of bit i
        sum_o = (a_i ^ b_i) ^ {g[14:0], 1'b0};
        co_o  = g[15];
    end

endmodule

module ppa_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [16*NREQ-1:0] req_a,
    input  logic [16*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_sum,
    output logic              rsp_co
);

    logic           rsp_valid_q, rsp_valid_d;
    logic [15:0]    rsp_sum_q, rsp_sum_d;
    logic           rsp_co_q, rsp_co_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           gnt_vld;
    logic [IDW-1:0] gnt_id;
    logic [IDW:0]   idx;
    logic [IDW-1:0] cand;
    logic           can_load;
    logic           accept;
    logic [IDW-1:0] ptr_nxt;
    logic [15:0]    op_a, op_b;
    logic [15:0]    add_sum;
    logic           add_co;

    // Reverse scan so the candidate closest to ptr is assigned last
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        cand    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            cand = idx[IDW-1:0];
            if (req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_id  = cand;
            end
        end
`ifdef PPA_ARBITER_STRICT0_EN
        if (req_valid[0]) begin
            gnt_vld = 1'b1;
            gnt_id  = '0;
        end
`endif
    end

    assign can_load  = ~rsp_valid_q | rsp_ready;
    assign req_ready = (gnt_vld & can_load & rst_n) ?
                       (NREQ'(1) << gnt_id) : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        op_a = '0;
        op_b = '0;
        if (gnt_vld) begin
            op_a = req_a[16*gnt_id +: 16];
            op_b = req_b[16*gnt_id +: 16];
        end
    end

    ppa u_ppa (
        .a_i   (op_a),
        .b_i   (op_b),
        .sum_o (add_sum),
        .co_o  (add_co)
    );

    assign ptr_nxt = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_co_d    = rsp_co_q;
        rsp_id_d    = rsp_id_q;
        ptr_d       = ptr_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = add_sum;
            rsp_co_d    = add_co;
            rsp_id_d    = gnt_id;
`ifdef PPA_ARBITER_STRICT0_EN
            if (gnt_id != '0) begin
                ptr_d = ptr_nxt;
            end
`else
            ptr_d = ptr_nxt;
`endif
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_co_q    <= 1'b0;
            rsp_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_co_q    <= rsp_co_d;
            rsp_id_q    <= rsp_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_co    = rsp_co_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_ppa_arbiter.sv
// Scoreboard bench for ppa_arbiter: random requesters, queue of expected responses.
// Builds with or without PPA_ARBITER_STRICT0_EN.
module tb_ppa_arbiter;

    localparam int N = 4;
`ifdef PPA_ARBITER_STRICT0_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [16*N-1:0]  req_a;
    logic [16*N-1:0]  req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [15:0]      rsp_sum;
    logic             rsp_co;

    always #5 clk = ~clk;

    ppa_arbiter #(.NREQ(N), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_co    (rsp_co)
    );

    typedef struct {
        int          id;
        logic [15:0] sum;
        logic        co;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] vld;
    logic [N-1:0] acc_prev;
    logic [N-1:0] en_mask;
    logic [15:0]  opa [N];
    logic [15:0]  opb [N];
    bit           cont;
    bit           use_fix;
    logic [15:0]  fix_a, fix_b;
    int           rr_pct;
    int           m_ptr;
    bit           m_valid;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Spec rule: first valid requester scanning from ptr with wrap
    function automatic int model_grant(input logic [N-1:0] v, input int p);
        if (STRICT && v[0]) return 0;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 4))
            0: return 16'hFFFF;
            1: return 16'h0000;
            2: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic step();
        int g;
        bit cl;
        logic [N-1:0] er;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (acc_prev[i] || !vld[i]) begin
                vld[i] = en_mask[i] && (cont || ($urandom_range(0, 1) == 1));
                opa[i] = use_fix ? fix_a : rand_op();
                opb[i] = use_fix ? fix_b : rand_op();
            end
        end
        rsp_ready = ($urandom_range(0, 99) < rr_pct);
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = vld[i];
            req_a[16*i +: 16] = opa[i];
            req_b[16*i +: 16] = opb[i];
        end
        @(negedge clk);
        #1;
        g  = model_grant(vld, m_ptr);
        cl = !m_valid || rsp_ready;
        er = '0;
        if (rst_n && g >= 0 && cl) er[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(er));
        acc_prev = er;
        if (!rst_n) begin
            sb.delete();
            m_ptr   = 0;
            m_valid = 1'b0;
        end else if (er != '0) begin
            e.id = g;
            {e.co, e.sum} = 17'(opa[g]) + 17'(opb[g]);
            sb.push_back(e);
            m_valid = 1'b1;
            if (!(STRICT && g == 0)) m_ptr = (g + 1) % N;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero();
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_sum", 32'(rsp_sum), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_co", 32'(rsp_co), 0);
    endtask

    task automatic quiesce();
        en_mask = '0;
        use_fix = 1'b0;
        rr_pct  = 100;
        repeat (8) step();
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("rsp_valid", 32'(rsp_valid), 32'(sb.size() != 0));
            if (rsp_valid && rsp_ready && sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                check("rsp_sum", 32'(rsp_sum), 32'(mon_e.sum));
                check("rsp_co", 32'(rsp_co), 32'(mon_e.co));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        vld       = '0;
        acc_prev  = '0;
        en_mask   = '1;
        cont      = 1'b1;
        use_fix   = 1'b0;
        fix_a     = '0;
        fix_b     = '0;
        rr_pct    = 100;
        m_ptr     = 0;
        m_valid   = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        // reset with all requesters valid, then continuous round robin
        step();
        check_zero();
        step();
        check_zero();
        step();
        check_zero();
        rst_n = 1'b1;
        repeat (6) step();
        quiesce();

        // lone requester 2: FFFF + 0001
        en_mask = 4'b0100;
        use_fix = 1'b1;
        fix_a   = 16'hFFFF;
        fix_b   = 16'h0001;
        step();
        check("single_valid", 32'(rsp_valid), 1);
        check("single_id", 32'(rsp_id), 2);
        check("single_sum", 32'(rsp_sum), 32'h0000);
        check("single_co", 32'(rsp_co), 1);
        quiesce();

        // ptr is 3, only requester 1: wraps to grant 1
        en_mask = 4'b0010;
        use_fix = 1'b1;
        fix_a   = 16'h8000;
        fix_b   = 16'h8000;
        step();
        check("wrap_id", 32'(rsp_id), 1);
        check("wrap_sum", 32'(rsp_sum), 32'h0000);
        check("wrap_co", 32'(rsp_co), 1);
        en_mask = '1;
        use_fix = 1'b0;
        step();
        check("wrap_next_id", 32'(rsp_id), STRICT ? 0 : 2);
        quiesce();

        // backpressure on a 1234+4321 result
        en_mask = 4'b0010;
        use_fix = 1'b1;
        fix_a   = 16'h1234;
        fix_b   = 16'h4321;
        step();
        en_mask = '1;
        use_fix = 1'b0;
        rr_pct  = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_sum", 32'(rsp_sum), 32'h5555);
        end
        rr_pct = 100;
        repeat (3) step();
        quiesce();

        // requesters 0 and 3 continuously
        en_mask = 4'b1001;
        repeat (12) step();
        quiesce();

        // random traffic with a reset in the middle
        en_mask = '1;
        cont    = 1'b0;
        rr_pct  = 60;
        for (int i = 0; i < 300; i++) begin
            rst_n = (i < 150 || i > 152);
            step();
        end
        quiesce();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
